result_nibble_streamer: RTL and testbench
=========================================

# result_nibble_streamer

Downstream output stage of the DCNN IO coordinator. After the CNN has written its result bytes to RAM, this block reads a contiguous byte range through the DMA read port. It emits each byte as two 4-bit nibbles on `Dout`, high nibble first, under a valid/ready handshake to the external consumer. It owns the RAM read request while busy; the coordinator selects its address and read signal onto the DMA whenever `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 16, RAM byte-address width and byte-count width
- `DATA_W`, 8, RAM data width; fixed at 8, two nibbles per word

Ports:
- `clk`  in  1  sole clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin streaming; sampled only in IDLE
- `baseAddr`  in  16  first RAM byte address; captured on accepted `start`
- `byteCount`  in  16  number of bytes to stream; captured on accepted `start`
- `ramAddress`  out  16  RAM read address to the DMA
- `readSignal`  out  1  RAM read request; held high until `doneRead`
- `doneRead`  in  1  DMA read-complete strobe; `ramDataIn` is valid in the same cycle
- `ramDataIn`  in  8  RAM read data
- `Dout`  out  4  output nibble
- `outValid`  out  1  `Dout` holds a valid nibble
- `outReady`  in  1  consumer accepts the nibble when `outValid` and `outReady` are both high
- `busy`  out  1  high from the accepted `start` until the cycle before `done`
- `done`  out  1  one-cycle pulse at end of stream

## Operation
- Reset is synchronous and active-high: on `RST=1` at a clock edge, the FSM goes to IDLE.
  - Reset values: `ramAddress=0`, `readSignal=0`, `Dout=0`, `outValid=0`, `busy=0`, `done=0`.
  - Internal address, remaining count and byte register are cleared.
  - Reset mid-stream abandons the transfer; no `done` pulse is produced.
- FSM states: IDLE, REQ, HI, LO, DONE.
- IDLE, on `start=1`:
  - Capture `baseAddr` into the address register and `byteCount` into the remaining counter.
  - If `byteCount != 0`, go to REQ. If `byteCount == 0`, go directly to DONE.
- REQ:
  - Drive `readSignal=1` and `ramAddress` = address register.
  - Hold both while `doneRead=0`.
  - On `doneRead=1`, latch `ramDataIn` into the byte register and go to HI. `readSignal` drops at that same edge.
- HI:
  - Drive `outValid=1` and `Dout` = byte[7:4].
  - On `outValid && outReady`, go to LO.
- LO:
  - Drive `outValid=1` and `Dout` = byte[3:0].
  - On handshake, increment the address (16-bit, wrapping `16'hFFFF -> 16'h0000`) and decrement the remaining count.
  - If the decremented count is 0, go to DONE; otherwise go to REQ.
- DONE: assert `done=1` for one cycle, `busy=0`, then return to IDLE.
- `start` while not in IDLE is ignored; no queueing.
- `outValid` and `Dout` are registered. `Dout` must not change while `outValid=1 && outReady=0`.
- `doneRead` outside REQ is ignored.
- Total nibbles emitted = 2 × `byteCount`, for `byteCount` from 1 to 65535.

## Timing
- Start to request: `start` accepted at edge N; `readSignal=1` and `busy=1` from cycle N+1.
- Read to output: `doneRead=1` in cycle K; `outValid=1` with the high nibble from cycle K+1.
- With `outReady` held at 1:
  - High nibble in cycle K+1, low nibble in K+2, next `readSignal` in K+3.
  - Per-byte cost: 3 cycles plus the DMA read latency.
- `done` is asserted in the cycle after the final low-nibble handshake. The block re-accepts `start` one cycle after `done`.
- `byteCount=0`: `done` is asserted in cycle N+1; `readSignal` and `outValid` never assert.
- `busy` is low in IDLE and DONE, high in REQ/HI/LO.
- No combinational path from `outReady` or `doneRead` to any output.

## Test plan
- Single byte:
  - Stimulus: `baseAddr=0x0010`, `byteCount=1`, RAM[0x10]=0xA5, `outReady=1`, DMA latency 2.
  - Required: one read at 0x0010, `Dout` 0xA then 0x5, `done` pulse, exactly 2 `outValid` handshakes.
- Multi-byte with back-pressure:
  - Stimulus: `byteCount=3` at 0x0100 holding 0x12, 0x34, 0x56; `outReady` toggles 1/0 every cycle.
  - Required: nibbles 1,2,3,4,5,6 in order; `Dout` stable while stalled; reads at 0x0100, 0x0101, 0x0102.
- Address wrap:
  - Stimulus: `baseAddr=0xFFFF`, `byteCount=2`, RAM[0xFFFF]=0xC3, RAM[0x0000]=0x7E.
  - Required: read addresses 0xFFFF then 0x0000; nibbles C,3,7,E.
- Zero length:
  - Stimulus: `byteCount=0`.
  - Required: `done` one cycle after `start`; `readSignal`, `outValid` and `busy` stay 0.
- Reset mid-operation:
  - Stimulus: assert `RST` during HI of byte 2 of 4.
  - Required: next cycle all outputs 0 and FSM in IDLE; no `done`; a new `start` then runs normally from its own `baseAddr`.
- Ignored start:
  - Stimulus: pulse `start` with a different `baseAddr` while in REQ.
  - Required: address and count unchanged; the stream completes as originally requested.

Source files
------------

// File: rtl/result_nibble_streamer.sv
// Output stage of the DCNN IO coordinator: reads a contiguous byte range over the
// DMA read port and streams each byte as high-then-low nibbles under valid/ready.
module result_nibble_streamer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W-1:0] byteCount,
  output logic [ADDR_W-1:0] ramAddress,
  output logic              readSignal,
  input  logic              doneRead,
  input  logic [DATA_W-1:0] ramDataIn,
  output logic [3:0]        Dout,
  output logic              outValid,
  input  logic              outReady,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] byte_q, byte_d;

  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic              read_signal_q, read_signal_d;
  logic [3:0]        dout_q, dout_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q       <= S_IDLE;
      addr_q        <= ADDR_ZERO;
      count_q       <= ADDR_ZERO;
      byte_q        <= {DATA_W{1'b0}};
      ram_address_q <= ADDR_ZERO;
      read_signal_q <= 1'b0;
      dout_q        <= 4'h0;
      out_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      byte_q        <= byte_d;
      ram_address_q <= ram_address_d;
      read_signal_q <= read_signal_d;
      dout_q        <= dout_d;
      out_valid_q   <= out_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = baseAddr;
          count_d = byteCount;
          state_d = (byteCount != ADDR_ZERO) ? S_REQ : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (doneRead) begin
          byte_d  = ramDataIn;
          state_d = S_HI;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HI: begin
        if (out_valid_q && outReady) begin
          state_d = S_LO;
        end else begin
          state_d = S_HI;
        end
      end
      S_LO: begin
        // Address wraps naturally at the top of the byte space
        if (out_valid_q && outReady) begin
          addr_d  = addr_q + ADDR_ONE;
          count_d = count_q - ADDR_ONE;
          state_d = (count_q == ADDR_ONE) ? S_DONE : S_REQ;
        end else begin
          state_d = S_LO;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so every port comes straight from a flop
  always_comb begin
    ram_address_d = ADDR_ZERO;
    read_signal_d = 1'b0;
    dout_d        = 4'h0;
    out_valid_d   = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state_d)
      S_IDLE: begin
        busy_d = 1'b0;
      end
      S_REQ: begin
        ram_address_d = addr_d;
        read_signal_d = 1'b1;
        busy_d        = 1'b1;
      end
      S_HI: begin
        dout_d      = byte_d[DATA_W-1 -: 4];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_LO: begin
        dout_d      = byte_d[3:0];
        out_valid_d = 1'b1;
        busy_d      = 1'b1;
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign ramAddress = ram_address_q;
  assign readSignal = read_signal_q;
  assign Dout       = dout_q;
  assign outValid   = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_result_nibble_streamer.sv
// Bench for result_nibble_streamer: table vectors, hand sequences and random
// streams checked against a byte-array RAM model and a nibble-order reference.
module tb_result_nibble_streamer;

  logic        clk = 1'b0;
  logic        RST, start, doneRead, outReady;
  logic [15:0] baseAddr, byteCount, ramAddress;
  logic [7:0]  ramDataIn;
  logic        readSignal, outValid, busy, done;
  logic [3:0]  Dout;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:65535];
  logic [3:0]  got_nib [$];
  logic [15:0] got_addr [$];

  typedef struct {
    logic [15:0] base;
    logic [15:0] cnt;
    int          lat;
    int          rmode;
    bit          ign;
    logic [31:0] bytes;
    logic [31:0] exp_nib;
  } vec_t;

  vec_t vecs [5];

  result_nibble_streamer #(.ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .RST(RST), .start(start), .baseAddr(baseAddr), .byteCount(byteCount),
    .ramAddress(ramAddress), .readSignal(readSignal), .doneRead(doneRead),
    .ramDataIn(ramDataIn), .Dout(Dout), .outValid(outValid), .outReady(outReady),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one stream starting at the current negedge; rst_nib >= 0 injects RST
  // while the nibble with that index is being presented.
  task automatic run_stream(input logic [15:0] base, input logic [15:0] cnt, input int lat,
                            input int rmode, input bit ign, input int rst_nib, output bit aborted);
    int cyc = 1;
    int rd_wait = 0;
    int busy_bad = 0;
    int stall_bad = 0;
    int rs_seen = 0;
    int ov_seen = 0;
    int done_cyc = 0;
    int late_done = 0;
    bit finished = 1'b0;
    bit prev_stall = 1'b0;
    logic [3:0] prev_dout = 4'h0;
    aborted = 1'b0;
    got_nib.delete();
    got_addr.delete();
    start = 1'b1; baseAddr = base; byteCount = cnt; doneRead = 1'b0; outReady = 1'b0;
    @(negedge clk);
    start = 1'b0; baseAddr = 16'($urandom); byteCount = 16'($urandom);
    while (!finished && !aborted && cyc < 3000) begin
      if (cyc == 1) begin
        chk("busy_after_start", 32'(busy), 32'(cnt != 16'd0));
        chk("read_after_start", 32'(readSignal), 32'(cnt != 16'd0));
      end
      if (readSignal) rs_seen++;
      if (outValid) ov_seen++;
      if (prev_stall && (!outValid || Dout !== prev_dout)) stall_bad++;
      if (done) begin
        finished = 1'b1;
        done_cyc = cyc;
        if (busy) busy_bad++;
      end else begin
        if (!busy) busy_bad++;
        start = ign && (cyc == 1);
        if (start) begin
          baseAddr = 16'h0600; byteCount = 16'd5;
        end
        doneRead = 1'b0;
        ramDataIn = 8'($urandom);
        if (readSignal) begin
          if (rd_wait >= lat) begin
            doneRead = 1'b1;
            ramDataIn = mem[ramAddress];
            got_addr.push_back(ramAddress);
            rd_wait = 0;
          end else begin
            rd_wait++;
          end
        end else begin
          rd_wait = 0;
          if (rmode == 2) doneRead = ($urandom_range(0, 3) == 0);
        end
        case (rmode)
          0: outReady = 1'b1;
          1: outReady = cyc[0];
          default: outReady = 1'($urandom_range(0, 1));
        endcase
        if (rst_nib >= 0 && outValid && got_nib.size() == rst_nib) begin
          RST = 1'b1; outReady = 1'b0; doneRead = 1'b0; start = 1'b0;
          @(negedge clk);
          RST = 1'b0;
          chk("reset_outputs", 32'({ramAddress, readSignal, Dout, outValid, busy, done}), 32'd0);
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done || busy) late_done++;
          end
          chk("no_done_after_reset", 32'(late_done), 32'd0);
          aborted = 1'b1;
        end else begin
          if (outValid && outReady) got_nib.push_back(Dout);
          prev_stall = outValid && !outReady;
          prev_dout = Dout;
          @(negedge clk);
          cyc++;
        end
      end
    end
    if (!aborted) begin
      chk("stream_timeout", 32'(finished), 32'd1);
      if (cnt == 16'd0) chk("zero_len_done_cycle", 32'(done_cyc), 32'd1);
      chk("busy_profile", 32'(busy_bad), 32'd0);
      chk("dout_stable_stall", 32'(stall_bad), 32'd0);
      chk("read_seen", 32'(rs_seen != 0), 32'(cnt != 16'd0));
      chk("valid_seen", 32'(ov_seen != 0), 32'(cnt != 16'd0));
      start = 1'b0; doneRead = 1'b0; outReady = 1'b0;
      @(negedge clk);
      chk("idle_after_done", 32'({readSignal, outValid, busy, done}), 32'd0);
    end
  endtask

  // Reference: byte i of the stream is RAM[base+i mod 2^16], high nibble first.
  task automatic check_model(input logic [15:0] base, input logic [15:0] cnt);
    logic [7:0]  b;
    logic [15:0] a;
    chk("nibble_count", 32'(got_nib.size()), 32'(cnt) * 32'd2);
    chk("read_count", 32'(got_addr.size()), 32'(cnt));
    for (int i = 0; i < int'(cnt); i++) begin
      a = 16'(base + 16'(i));
      b = mem[a];
      if (i < got_addr.size()) chk("read_addr", 32'(got_addr[i]), 32'(a));
      if (2 * i + 1 < got_nib.size()) begin
        chk("nibble_hi", 32'(got_nib[2 * i]), 32'(b[7:4]));
        chk("nibble_lo", 32'(got_nib[2 * i + 1]), 32'(b[3:0]));
      end
    end
  endtask

  initial begin
    bit ab;
    logic [31:0] pack;
    logic [15:0] rb, rc;
    RST = 1'b1; start = 1'b0; baseAddr = 16'h0000; byteCount = 16'h0000;
    doneRead = 1'b0; ramDataIn = 8'h00; outReady = 1'b0;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    vecs[0] = '{16'h0010, 16'd1, 2, 0, 1'b0, 32'h0000_00A5, 32'h0000_00A5};
    vecs[1] = '{16'h0100, 16'd3, 1, 1, 1'b0, 32'h0012_3456, 32'h0012_3456};
    vecs[2] = '{16'hFFFF, 16'd2, 1, 0, 1'b0, 32'h0000_C37E, 32'h0000_C37E};
    vecs[3] = '{16'h1234, 16'd0, 0, 0, 1'b0, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{16'h0500, 16'd2, 3, 0, 1'b1, 32'h0000_9ABC, 32'h0000_9ABC};

    repeat (3) @(negedge clk);
    chk("reset_state", 32'({ramAddress, readSignal, Dout, outValid, busy, done}), 32'd0);
    RST = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < int'(vecs[v].cnt); k++)
        mem[16'(vecs[v].base + 16'(k))] = vecs[v].bytes[8 * (int'(vecs[v].cnt) - 1 - k) +: 8];
      run_stream(vecs[v].base, vecs[v].cnt, vecs[v].lat, vecs[v].rmode, vecs[v].ign, -1, ab);
      check_model(vecs[v].base, vecs[v].cnt);
      pack = 32'd0;
      foreach (got_nib[i]) pack = (pack << 4) | 32'(got_nib[i]);
      chk("table_nibbles", pack, vecs[v].exp_nib);
    end

    // Reset while the high nibble of byte 2 of 4 is on the bus, then a clean restart
    run_stream(16'h0300, 16'd4, 1, 0, 1'b0, 2, ab);
    chk("reset_reached_hi_byte2", 32'(ab), 32'd1);
    run_stream(16'h0400, 16'd2, 2, 1, 1'b0, -1, ab);
    check_model(16'h0400, 16'd2);

    for (int r = 0; r < 25; r++) begin
      rb = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      rc = 16'($urandom_range(1, 5));
      run_stream(rb, rc, $urandom_range(0, 3), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0), -1, ab);
      check_model(rb, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
